// File: rtl/multdiv_ctrl.sv
// Sequencing control for an iterative multiply/divide unit sitting beside the X stage:
// it launches the unit, stalls the front end while it runs and issues a single writeback.
module multdiv_ctrl #(
    parameter int TIMEOUT  = 40,
    parameter int CODE_MUL = 4,
    parameter int CODE_DIV = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid_in,
    input  logic [4:0]  i_opcode,
    input  logic [4:0]  i_aluop,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic        i_flush,
    input  logic [31:0] i_data_result,
    input  logic        i_data_exception,
    input  logic        i_data_resultrdy,
    output logic        o_ctrl_mult,
    output logic        o_ctrl_div,
    output logic [31:0] o_unit_a,
    output logic [31:0] o_unit_b,
    output logic        o_stall,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_is_div;
    logic          r_wb_en;
    logic [4:0]    r_rd;
    logic          w_start;
    logic          w_timeout;
    logic          w_capture;
    logic          w_exc;

    // Reset is folded in so stall reads 0 while reset is held, even with a mul/div in X.
    assign w_start = i_rst_n && (r_state == S_IDLE) && i_valid_in && (i_opcode == 5'b00000)
                     && ((i_aluop == 5'b00110) || (i_aluop == 5'b00111)) && !i_flush;

    // The counter holds the number of BUSY cycles already completed, so this fires
    // in the TIMEOUT-th BUSY cycle, bounding BUSY to TIMEOUT cycles.
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
    assign w_exc     = !i_data_resultrdy || i_data_exception;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_BUSY;
            S_BUSY: begin
                if (i_flush) begin
                    w_state_nxt = S_IDLE;
                end else if (i_data_resultrdy || w_timeout) begin
                    w_state_nxt = S_DONE;
                    w_capture   = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_stall     = w_start || (r_state == S_BUSY);
    assign o_ctrl_mult = (r_state == S_BUSY) && (r_cnt == '0) && !r_is_div;
    assign o_ctrl_div  = (r_state == S_BUSY) && (r_cnt == '0) && r_is_div;
    assign o_wb_valid  = (r_state == S_DONE) && r_wb_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_rd      <= '0;
            r_wb_en   <= 1'b0;
            o_unit_a  <= '0;
            o_unit_b  <= '0;
            o_wb_rd   <= '0;
            o_wb_data <= '0;
        end else begin
            if (w_start) begin
                o_unit_a <= i_op_a;
                o_unit_b <= i_op_b;
                r_rd     <= i_rd;
                r_is_div <= i_aluop[0];
                r_cnt    <= '0;
            end else if ((r_state == S_BUSY) && (r_cnt != CW'(TIMEOUT))) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_capture) begin
                // A timeout is reported exactly like a unit exception.
                o_wb_rd   <= w_exc ? 5'd30 : r_rd;
                o_wb_data <= w_exc ? (r_is_div ? 32'(CODE_DIV) : 32'(CODE_MUL)) : i_data_result;
                r_wb_en   <= w_exc || (r_rd != 5'd0);
            end
        end
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: decode table, directed corner sequences and random
// transactions checked against a transaction-level outcome model.
module tb_multdiv_ctrl;
    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in, flush, rdy, exc_in;
    logic [4:0]  opcode, aluop, rd;
    logic [31:0] op_a, op_b, result;
    logic        ctrl_mult, ctrl_div, stall, wb_valid;
    logic [31:0] unit_a, unit_b, wb_data;
    logic [4:0]  wb_rd;

    int n_cmp = 0;
    int n_err = 0;

    multdiv_ctrl #(.TIMEOUT(TO), .CODE_MUL(4), .CODE_DIV(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid_in(valid_in), .i_opcode(opcode),
        .i_aluop(aluop), .i_rd(rd), .i_op_a(op_a), .i_op_b(op_b), .i_flush(flush),
        .i_data_result(result), .i_data_exception(exc_in), .i_data_resultrdy(rdy),
        .o_ctrl_mult(ctrl_mult), .o_ctrl_div(ctrl_div), .o_unit_a(unit_a), .o_unit_b(unit_b),
        .o_stall(stall), .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; opcode = '0; aluop = '0; rd = '0; op_a = '0; op_b = '0;
        flush = 1'b0; rdy = 1'b0; exc_in = 1'b0; result = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " stall"}, 32'(stall), 0);
        chk({tag, " ctrl"}, 32'({ctrl_mult, ctrl_div}), 0);
        chk({tag, " wb_valid"}, 32'(wb_valid), 0);
        chk({tag, " unit_a"}, unit_a, 0);
        chk({tag, " unit_b"}, unit_b, 0);
        chk({tag, " wb_rd"}, 32'(wb_rd), 0);
        chk({tag, " wb_data"}, wb_data, 0);
    endtask

    // Outcome of one operation, derived from the rules at transaction level.
    typedef struct {
        int          busy_len;
        bit          flushed;
        bit          wb_v;
        logic [4:0]  wrd;
        logic [31:0] wdata;
    } exp_t;

    function automatic exp_t predict(input bit is_div, input logic [4:0] r, input int rdy_at,
                                     input bit exc, input logic [31:0] res, input int flush_at);
        exp_t e;
        int   end_rdy;
        int   stop;
        end_rdy   = (rdy_at >= 1 && rdy_at <= TO) ? rdy_at : 0;
        stop      = (end_rdy != 0) ? end_rdy : TO;
        e.flushed = (flush_at >= 1 && flush_at <= stop);
        e.busy_len = e.flushed ? flush_at : stop;
        if (end_rdy != 0 && !exc) begin
            e.wrd = r; e.wdata = res; e.wb_v = (r != 0);
        end else begin
            e.wrd = 5'd30; e.wdata = is_div ? 32'd5 : 32'd4; e.wb_v = 1'b1;
        end
        if (e.flushed) e.wb_v = 1'b0;
        return e;
    endfunction

    // One mul/div; the instruction stays in X while stalled and through DONE.
    task automatic run_op(input string tag, input bit is_div, input logic [4:0] r,
                          input logic [31:0] a, input logic [31:0] b, input int rdy_at,
                          input bit exc, input logic [31:0] res, input int flush_at,
                          input bit flush_in_done);
        exp_t e;
        e = predict(is_div, r, rdy_at, exc, res, flush_at);
        @(negedge clk);
        valid_in = 1'b1; opcode = 5'd0; aluop = is_div ? 5'd7 : 5'd6; rd = r;
        op_a = a; op_b = b; flush = 1'b0; rdy = 1'b0;
        #1;
        chk({tag, " accept stall"}, 32'(stall), 1);
        chk({tag, " accept ctrl"}, 32'({ctrl_mult, ctrl_div}), 0);
        for (int c = 1; c <= e.busy_len; c++) begin
            @(negedge clk);
            rdy = (c == rdy_at); exc_in = exc; result = res; flush = (c == flush_at);
            op_a = $urandom; op_b = $urandom; rd = 5'($urandom);
            #1;
            chk({tag, " busy stall"}, 32'(stall), 1);
            chk({tag, " ctrl_mult"}, 32'(ctrl_mult), 32'(c == 1 && !is_div));
            chk({tag, " ctrl_div"}, 32'(ctrl_div), 32'(c == 1 && is_div));
            chk({tag, " unit_a"}, unit_a, a);
            chk({tag, " unit_b"}, unit_b, b);
            chk({tag, " busy wb_valid"}, 32'(wb_valid), 0);
        end
        @(negedge clk);
        flush = flush_in_done; rdy = 1'b1; exc_in = 1'b0; result = 32'hBAD0BAD0;
        op_a = a; op_b = b; rd = r;
        if (e.flushed) valid_in = 1'b0;
        #1;
        chk({tag, " post stall"}, 32'(stall), 0);
        chk({tag, " post ctrl"}, 32'({ctrl_mult, ctrl_div}), 0);
        chk({tag, " wb_valid"}, 32'(wb_valid), 32'(e.wb_v));
        if (e.wb_v) begin
            chk({tag, " wb_rd"}, 32'(wb_rd), 32'(e.wrd));
            chk({tag, " wb_data"}, wb_data, e.wdata);
        end
        @(negedge clk);
        valid_in = 1'b0; flush = 1'b0; rdy = 1'b1;
        #1;
        chk({tag, " idle stall"}, 32'(stall), 0);
        chk({tag, " idle ctrl"}, 32'({ctrl_mult, ctrl_div}), 0);
        chk({tag, " idle wb_valid"}, 32'(wb_valid), 0);
        @(negedge clk);
        rdy = 1'b0;
        #1;
        chk({tag, " idle2 wb_valid"}, 32'(wb_valid), 0);
        chk({tag, " idle2 stall"}, 32'(stall), 0);
    endtask

    typedef struct {
        logic       v;
        logic [4:0] opc;
        logic [4:0] alu;
        logic       fl;
        logic       exp_stall;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 5'd0,  5'd6, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 5'd0,  5'd7, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 5'd0,  5'd6, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 5'd0,  5'd7, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 5'd1,  5'd6, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 5'd0,  5'd5, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 5'd0,  5'd8, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 5'd0,  5'd0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 5'h10, 5'd7, 1'b0, 1'b0};

        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        #1 chk_all_zero("reset");
        rst_n = 1'b1;

        // Start decode: stall is combinational, so inputs are withdrawn before the edge.
        foreach (tbl[i]) begin
            @(negedge clk);
            valid_in = tbl[i].v; opcode = tbl[i].opc; aluop = tbl[i].alu; flush = tbl[i].fl;
            #1;
            chk($sformatf("decode[%0d] stall", i), 32'(stall), 32'(tbl[i].exp_stall));
            chk($sformatf("decode[%0d] ctrl", i), 32'({ctrl_mult, ctrl_div}), 0);
            chk($sformatf("decode[%0d] wb_valid", i), 32'(wb_valid), 0);
            valid_in = 1'b0; flush = 1'b0;
        end

        run_op("mul7x6",    1'b0, 5'd3, 32'd7,  32'd6, 17, 1'b0, 32'd42, 0, 1'b0);
        run_op("div10by0",  1'b1, 5'd5, 32'd10, 32'd0, 8,  1'b1, 32'hDEAD, 0, 1'b0);
        run_op("mul_tmo",   1'b0, 5'd4, 32'd3,  32'd9, 0,  1'b0, 32'd0, 0, 1'b0);
        run_op("div_flrdy", 1'b1, 5'd6, 32'd99, 32'd3, 12, 1'b0, 32'd33, 12, 1'b0);
        run_op("mul_rd0",   1'b0, 5'd0, 32'd3,  32'd3, 5,  1'b0, 32'd9, 0, 1'b0);
        run_op("rdy_last",  1'b1, 5'd9, 32'd8,  32'd2, TO, 1'b0, 32'd4, 0, 1'b0);
        run_op("rdy_late",  1'b1, 5'd9, 32'd8,  32'd2, TO + 1, 1'b0, 32'd4, 0, 1'b0);
        run_op("rdy_first", 1'b0, 5'd1, 32'd2,  32'd2, 1,  1'b0, 32'd4, 0, 1'b1);

        // Reset in the middle of an operation, instruction still presented.
        @(negedge clk);
        valid_in = 1'b1; opcode = 5'd0; aluop = 5'd6; rd = 5'd7; op_a = 32'd3; op_b = 32'd5;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        #1 chk_all_zero("midreset held");
        idle_inputs();
        rst_n = 1'b1;
        #1 chk_all_zero("after reset");
        run_op("post_reset", 1'b0, 5'd7, 32'd3, 32'd5, 6, 1'b0, 32'd15, 0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            bit          r_div, r_exc, r_fd;
            logic [4:0]  r_rd;
            int          r_rdy, r_fl;
            r_div = 1'($urandom);
            r_exc = ($urandom_range(0, 3) == 0);
            r_fd  = 1'($urandom);
            r_rd  = 5'($urandom);
            r_rdy = $urandom_range(0, TO + 4);
            r_fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO + 4) : 0;
            run_op($sformatf("rand%0d", n), r_div, r_rd, $urandom, $urandom, r_rdy, r_exc,
                   $urandom, r_fl, r_fd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
